// File: rtl/gshare_pattern_history_table_pkg.sv
// Shared branch-predictor types and constants.
// Two-bit counter encoding and default history width.
package gshare_pattern_history_table_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SNT = 2'b00;
  localparam ctr2_t WNT = 2'b01;
  localparam ctr2_t WT  = 2'b10;
  localparam ctr2_t ST  = 2'b11;

  localparam int GHR_WIDTH_DEF = 4;

endpackage

// File: rtl/gshare_pattern_history_table_sat_counter2.sv
// Next-state function of a 2-bit saturating
// up/down counter.
module gshare_pattern_history_table_sat_counter2
  import gshare_pattern_history_table_pkg::*;
(
  input  ctr2_t cnt_i,
  input  logic  up_i,
  output ctr2_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    unique case (1'b1)
      (up_i && cnt_i != ST):   cnt_o = cnt_i + 2'd1;
      (!up_i && cnt_i != SNT): cnt_o = cnt_i - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/gshare_pattern_history_table.sv
// Gshare pattern history table: fetch-side lookup,
// execute-side training and perf counters.
module gshare_pattern_history_table
  import gshare_pattern_history_table_pkg::*;
#(
  parameter int    GHR_WIDTH  = GHR_WIDTH_DEF,
  parameter int    PC_LSB     = 2,
  parameter ctr2_t INIT_STATE = WNT,
  parameter int    PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           PC_F,
  input  logic [GHR_WIDTH-1:0]  GHR_value,
  output logic [GHR_WIDTH-1:0]  pht_index_F,
  output logic                  predictTaken_F,
  input  logic                  branch_E,
  input  logic                  bne_E,
  input  logic                  realValue_E,
  input  logic [GHR_WIDTH-1:0]  pht_index_E,
  input  logic                  predictTaken_E,
  output logic                  mispredict_E,
  output logic [PERF_WIDTH-1:0] branch_count,
  output logic [PERF_WIDTH-1:0] mispredict_count
);

  localparam int N = 1 << GHR_WIDTH;

  ctr2_t pht_q [N];
  ctr2_t upd_cur;
  ctr2_t upd_nxt;
  logic  resolve;
  logic  taken;
  logic  collide;
  logic  unused_pc;

  logic [PERF_WIDTH-1:0] branch_count_q;
  logic [PERF_WIDTH-1:0] branch_count_d;
  logic [PERF_WIDTH-1:0] mispredict_count_q;
  logic [PERF_WIDTH-1:0] mispredict_count_d;

  assign unused_pc = ^{PC_F[31:PC_LSB+GHR_WIDTH],
                       PC_F[PC_LSB-1:0]};

  assign pht_index_F =
    PC_F[PC_LSB +: GHR_WIDTH] ^ GHR_value;

  // beq wins when both resolve flags are set
  assign resolve = branch_E | bne_E;
  assign taken   = branch_E ? realValue_E
                            : ~realValue_E;

  assign mispredict_E =
    resolve & (taken != predictTaken_E);

  assign upd_cur = pht_q[pht_index_E];

  gshare_pattern_history_table_sat_counter2
    u_sat_counter2 (
      .cnt_i (upd_cur),
      .up_i  (taken),
      .cnt_o (upd_nxt)
    );

  // write-through so a same-cycle read sees the update
  assign collide = resolve &&
                   (pht_index_E == pht_index_F);

  assign predictTaken_F =
    collide ? upd_nxt[1] : pht_q[pht_index_F][1];

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && branch_count_q != '1)
      branch_count_d = branch_count_q
                       + PERF_WIDTH'(1);
    if (mispredict_E && mispredict_count_q != '1)
      mispredict_count_d = mispredict_count_q
                           + PERF_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        pht_q[i] <= INIT_STATE;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (resolve)
        pht_q[pht_index_E] <= upd_nxt;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_gshare_pattern_history_table.sv
// Scoreboard bench for the gshare PHT: reference
// model predicts outputs per step, compared at mid-cycle.
module tb_gshare_pattern_history_table;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_F;
  logic [3:0]  GHR_value;
  logic [3:0]  pht_index_F;
  logic        predictTaken_F;
  logic        branch_E;
  logic        bne_E;
  logic        realValue_E;
  logic [3:0]  pht_index_E;
  logic        predictTaken_E;
  logic        mispredict_E;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  gshare_pattern_history_table dut (
    .clk              (clk),
    .reset            (reset),
    .PC_F             (PC_F),
    .GHR_value        (GHR_value),
    .pht_index_F      (pht_index_F),
    .predictTaken_F   (predictTaken_F),
    .branch_E         (branch_E),
    .bne_E            (bne_E),
    .realValue_E      (realValue_E),
    .pht_index_E      (pht_index_E),
    .predictTaken_E   (predictTaken_E),
    .mispredict_E     (mispredict_E),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  typedef struct packed {
    logic        rst;
    logic [31:0] pc;
    logic [3:0]  ghr;
    logic        br;
    logic        bne;
    logic        rv;
    logic [3:0]  idx_e;
    logic        pred_e;
  } stim_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic        pred;
    logic        misp;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t        sbq[$];
  logic [1:0]  model [16];
  logic [15:0] m_bc;
  logic [15:0] m_mc;
  int          total  = 0;
  int          passed = 0;

  function automatic stim_t mk(
    input logic rst, input logic [31:0] pc,
    input logic [3:0] ghr, input logic br,
    input logic bne, input logic rv,
    input logic [3:0] idx_e, input logic pred_e);
    stim_t s;
    s = '{rst, pc, ghr, br, bne, rv, idx_e, pred_e};
    return s;
  endfunction

  function automatic logic [1:0] sat2(
    input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 2'b01;
    m_bc = '0;
    m_mc = '0;
  endtask

  // Drives one cycle of inputs and queues the outputs
  // the reference expects before the next edge.
  task automatic drive(input stim_t s);
    exp_t       e;
    logic       res;
    logic       tk;
    logic [3:0] idxf;
    logic [1:0] nx;
    reset          = s.rst;
    PC_F           = s.pc;
    GHR_value      = s.ghr;
    branch_E       = s.br;
    bne_E          = s.bne;
    realValue_E    = s.rv;
    pht_index_E    = s.idx_e;
    predictTaken_E = s.pred_e;
    idxf = s.pc[5:2] ^ s.ghr;
    res  = s.br | s.bne;
    tk   = s.br ? s.rv : ~s.rv;
    nx   = sat2(model[s.idx_e], tk);
    e.idx  = idxf;
    e.pred = (res && s.idx_e == idxf) ? nx[1]
                                      : model[idxf][1];
    e.misp = res && (tk != s.pred_e);
    e.bc   = m_bc;
    e.mc   = m_mc;
    sbq.push_back(e);
    if (s.rst) begin
      model_reset();
    end else if (res) begin
      model[s.idx_e] = nx;
      if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
      if (e.misp && m_mc != 16'hFFFF)
        m_mc = m_mc + 16'd1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    PC_F = '0; GHR_value = '0;
    branch_E = 1'b1; bne_E = 1'b0; realValue_E = 1'b1;
    pht_index_E = 4'd4; predictTaken_E = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    drive(mk(0, 32'h10, 4'h0, 0, 0, 0, 4'h0, 0));
    #3;
    e = sbq.pop_front();
    total++;
    if ({pht_index_F, predictTaken_F, mispredict_E,
         branch_count, mispredict_count} !== e)
      $display("FAIL reset_sb: got %h exp %h",
        {pht_index_F, predictTaken_F, mispredict_E,
         branch_count, mispredict_count}, e);
    else passed++;
    total++;
    if (pht_index_F !== 4'b0100 || predictTaken_F !== 1'b0
        || branch_count !== 16'd0
        || mispredict_count !== 16'd0)
      $display("FAIL reset_const: idx=%h pred=%b bc=%h mc=%h exp 4 0 0 0",
        pht_index_F, predictTaken_F, branch_count,
        mispredict_count);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_train_taken();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(0, 32'h0, 4'h0, 1, 0, 1, 4'd4, 0));
    s.push_back(mk(0, 32'h0, 4'h4, 0, 0, 0, 4'd0, 0));
    s.push_back(mk(0, 32'h0, 4'h0, 1, 0, 1, 4'd4, 1));
    s.push_back(mk(0, 32'h0, 4'h0, 1, 0, 1, 4'd4, 1));
    s.push_back(mk(0, 32'h0, 4'h0, 1, 0, 0, 4'd4, 1));
    s.push_back(mk(0, 32'h0, 4'h4, 0, 0, 0, 4'd0, 0));
    s.push_back(mk(0, 32'h0, 4'h0, 1, 0, 0, 4'd4, 1));
    s.push_back(mk(0, 32'h0, 4'h4, 0, 0, 0, 4'd0, 0));
    foreach (s[i]) begin
      drive(s[i]);
      #3;
      e = sbq.pop_front();
      total++;
      if ({pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count} !== e)
        $display("FAIL train_taken step%0d: got %h exp %h", i,
          {pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count}, e);
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (branch_count !== 16'd5 || mispredict_count !== 16'd3)
      $display("FAIL train_counts: bc=%0d mc=%0d exp 5 3",
        branch_count, mispredict_count);
    else passed++;
  endtask

  task automatic test_bne_saturate();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(0, 32'h0,  4'h0, 0, 1, 1, 4'd9, 0));
    s.push_back(mk(0, 32'h0,  4'h0, 0, 1, 1, 4'd9, 0));
    s.push_back(mk(0, 32'h24, 4'h0, 0, 1, 0, 4'd9, 1));
    s.push_back(mk(0, 32'h0,  4'h0, 1, 1, 0, 4'd9, 0));
    s.push_back(mk(0, 32'h0,  4'h0, 1, 1, 1, 4'd9, 1));
    foreach (s[i]) begin
      drive(s[i]);
      #3;
      e = sbq.pop_front();
      total++;
      if ({pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count} !== e)
        $display("FAIL bne_saturate step%0d: got %h exp %h", i,
          {pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count}, e);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_collision();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(0, 32'h4,  4'h4, 1, 0, 1, 4'd5, 0));
    s.push_back(mk(0, 32'h4,  4'h4, 0, 0, 0, 4'd0, 0));
    s.push_back(mk(0, 32'h14, 4'h0, 1, 0, 0, 4'd5, 1));
    foreach (s[i]) begin
      drive(s[i]);
      #3;
      e = sbq.pop_front();
      total++;
      if ({pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count} !== e)
        $display("FAIL collision step%0d: got %h exp %h", i,
          {pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count}, e);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    stim_t s[$];
    exp_t  e;
    s.push_back(mk(0, 32'h0, 4'h0, 1, 0, 1, 4'd3, 0));
    s.push_back(mk(0, 32'h0, 4'h0, 1, 0, 1, 4'd3, 1));
    s.push_back(mk(0, 32'hC, 4'h0, 0, 0, 0, 4'd0, 0));
    s.push_back(mk(1, 32'hC, 4'h0, 1, 0, 0, 4'd3, 1));
    s.push_back(mk(0, 32'hC, 4'h0, 0, 0, 0, 4'd0, 0));
    s.push_back(mk(0, 32'hC, 4'h0, 1, 0, 1, 4'd3, 0));
    foreach (s[i]) begin
      drive(s[i]);
      #3;
      e = sbq.pop_front();
      total++;
      if ({pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count} !== e)
        $display("FAIL reset_midop step%0d: got %h exp %h", i,
          {pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count}, e);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf_saturate();
    exp_t e;
    int   bad = 0;
    drive(mk(1, 32'h0, 4'h0, 0, 0, 0, 4'd0, 0));
    void'(sbq.pop_front());
    @(posedge clk); #1;
    for (int i = 0; i < 65536 + 3; i++) begin
      drive(mk(0, 32'h0, 4'h0, 1, 0, 0, 4'd1, 1));
      #3;
      e = sbq.pop_front();
      total++;
      if ({pht_index_F, predictTaken_F, mispredict_E,
           branch_count, mispredict_count} !== e) begin
        if (bad < 5)
          $display("FAIL perf step%0d: got %h exp %h", i,
            {pht_index_F, predictTaken_F, mispredict_E,
             branch_count, mispredict_count}, e);
        bad++;
      end else passed++;
      @(posedge clk); #1;
    end
    drive(mk(0, 32'h0, 4'h0, 0, 0, 0, 4'd0, 0));
    void'(sbq.pop_front());
    #3;
    total++;
    if (branch_count !== 16'hFFFF
        || mispredict_count !== 16'hFFFF)
      $display("FAIL perf_sat: bc=%h mc=%h exp ffff ffff",
        branch_count, mispredict_count);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    PC_F = '0; GHR_value = '0;
    branch_E = 1'b0; bne_E = 1'b0; realValue_E = 1'b0;
    pht_index_E = '0; predictTaken_E = 1'b0;
    m_bc = '0; m_mc = '0;
    test_reset();
    test_train_taken();
    test_bne_saturate();
    test_collision();
    test_reset_midop();
    test_perf_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
